// File: rtl/vec_mem_seq.sv
//------------------------------------------------------------------------------
// vec_mem_seq
//
// Memory sequencer for the CVP14 vector load (VLD) and vector store (VST)
// instructions. It sits between the external memory port and the vector
// register file's parallel port. It moves NELEM consecutive DW-bit words
// between memory at BaseAddr+i and one vector register.
//
// Ports
//   Clk1      clock; all state and outputs update on posedge
//   Reset     synchronous, active-high reset (priority over everything)
//   Start     begin a transfer; sampled only in IDLE
//   Op        0 = load (VLD), 1 = store (VST); sampled with Start
//   BaseAddr  address of element 0; sampled with Start
//   VecIn     vector to store; snapshotted with Start
//   DataIn    memory read data for the address presented in this cycle
//   Addr      memory address (registered)
//   RD / WR   memory read / write strobes (registered, never both high)
//   DataOut   memory write data (registered)
//   VecOut    assembled load vector, element i at [DW*i +: DW]
//   VecWrEn   one-cycle pulse: VecOut complete, write it to the register file
//   Busy      high in every state except IDLE
//   Done      one-cycle pulse at the end of any transfer
//
// Timing, with edge 0 being the edge that accepts Start:
//   after edge k (k = 1..NELEM) element k-1 is on the memory port;
//   for loads, edge k+1 captures DataIn into element k-1;
//   after edge NELEM+1 the sequencer sits in DONE for one cycle.
//------------------------------------------------------------------------------
module vec_mem_seq #(
   parameter int NELEM = 16,
   parameter int DW    = 16
) (
   input  logic                Clk1,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Op,
   input  logic [15:0]         BaseAddr,
   input  logic [NELEM*DW-1:0] VecIn,
   input  logic [DW-1:0]       DataIn,
   output logic [15:0]         Addr,
   output logic                RD,
   output logic                WR,
   output logic [DW-1:0]       DataOut,
   output logic [NELEM*DW-1:0] VecOut,
   output logic                VecWrEn,
   output logic                Busy,
   output logic                Done
);

   // cnt counts cycles since the Start edge and must reach NELEM itself.
   localparam int CW = $clog2(NELEM + 1);
   localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STORE,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [CW-1:0] cnt;
   logic          op_q;
   logic [15:0]   base_q;
   logic [DW-1:0] st_buf  [NELEM];
   logic [DW-1:0] ld_elem [NELEM];

   logic          last;
   logic [IW-1:0] issue_idx;
   logic [IW-1:0] cap_idx;

   // The cycle with cnt == NELEM only collects the final read; no new issue.
   assign last      = (cnt == CW'(NELEM));
   assign issue_idx = IW'(cnt);
   // The word read in the previous cycle belongs to element cnt-1.
   assign cap_idx   = IW'(cnt - CW'(1));

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (Start) begin
               state_nxt = Op ? S_STORE : S_LOAD;
            end
         end
         S_LOAD,
         S_STORE: begin
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Start is deliberately ignored here, which forces one idle cycle.
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath: memory port, element counter, store buffer, load assembly
   //---------------------------------------------------------------------------
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         cnt     <= '0;
         op_q    <= 1'b0;
         base_q  <= '0;
         Addr    <= '0;
         RD      <= 1'b0;
         WR      <= 1'b0;
         DataOut <= '0;
         for (int i = 0; i < NELEM; i++) begin
            st_buf[i]  <= '0;
            ld_elem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  op_q   <= Op;
                  base_q <= BaseAddr;
                  cnt    <= '0;
                  // Snapshot so later VecIn changes cannot corrupt the store.
                  for (int i = 0; i < NELEM; i++) begin
                     st_buf[i] <= VecIn[i*DW +: DW];
                  end
               end
            end
            S_LOAD: begin
               if (!last) begin
                  cnt  <= cnt + CW'(1);
                  Addr <= base_q + 16'(cnt);
                  RD   <= 1'b1;
               end else begin
                  RD   <= 1'b0;
               end
               // RD high in the previous cycle means DataIn is for element cnt-1.
               if (RD) begin
                  ld_elem[cap_idx] <= DataIn;
               end
            end
            S_STORE: begin
               if (!last) begin
                  cnt     <= cnt + CW'(1);
                  Addr    <= base_q + 16'(cnt);
                  WR      <= 1'b1;
                  DataOut <= st_buf[issue_idx];
               end else begin
                  WR      <= 1'b0;
               end
            end
            default: begin
               RD <= 1'b0;
               WR <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NELEM; g++) begin : g_vec_out
      assign VecOut[g*DW +: DW] = ld_elem[g];
   end

   assign Busy    = (state != S_IDLE);
   assign Done    = (state == S_DONE);
   assign VecWrEn = (state == S_DONE) && !op_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
//------------------------------------------------------------------------------
// tb_vec_mem_seq
//
// Directed bench for vec_mem_seq. A combinational memory model returns
// 0xA000 + (Addr - mem_base) for whatever address the sequencer presents.
//------------------------------------------------------------------------------
module tb_vec_mem_seq;

   localparam int NELEM = 16;
   localparam int DW    = 16;

   logic                Clk1;
   logic                Reset;
   logic                Start;
   logic                Op;
   logic [15:0]         BaseAddr;
   logic [NELEM*DW-1:0] VecIn;
   logic [DW-1:0]       DataIn;
   logic [15:0]         Addr;
   logic                RD;
   logic                WR;
   logic [DW-1:0]       DataOut;
   logic [NELEM*DW-1:0] VecOut;
   logic                VecWrEn;
   logic                Busy;
   logic                Done;

   logic [15:0]         mem_base;
   int                  n_checks;
   int                  n_fail;

   vec_mem_seq #(
      .NELEM(NELEM),
      .DW   (DW)
   ) dut (
      .Clk1    (Clk1),
      .Reset   (Reset),
      .Start   (Start),
      .Op      (Op),
      .BaseAddr(BaseAddr),
      .VecIn   (VecIn),
      .DataIn  (DataIn),
      .Addr    (Addr),
      .RD      (RD),
      .WR      (WR),
      .DataOut (DataOut),
      .VecOut  (VecOut),
      .VecWrEn (VecWrEn),
      .Busy    (Busy),
      .Done    (Done)
   );

   initial begin
      Clk1 = 1'b0;
      forever #5 Clk1 = ~Clk1;
   end

   assign DataIn = 16'hA000 + (Addr - mem_base);

   task automatic tick();
      @(posedge Clk1);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [NELEM*DW-1:0] obs,
                       input logic [NELEM*DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NELEM*DW-1:0] load_vec();
      logic [NELEM*DW-1:0] v;
      for (int i = 0; i < NELEM; i++) begin
         v[i*DW +: DW] = 16'hA000 + 16'(i);
      end
      return v;
   endfunction

   function automatic logic [NELEM*DW-1:0] store_vec();
      logic [NELEM*DW-1:0] v;
      for (int i = 0; i < NELEM; i++) begin
         v[i*DW +: DW] = 16'(32'h1111 * (i + 1));
      end
      return v;
   endfunction

   // Complete load from base, checking every cycle of the transfer.
   task automatic do_load(input logic [15:0] base);
      mem_base = base;
      BaseAddr = base;
      Op       = 1'b0;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      chk1("ld_busy_e0", Busy, 1'b1);
      chk1("ld_rd_e0", RD, 1'b0);
      for (int k = 1; k <= NELEM; k++) begin
         tick();
         chk16("ld_addr", Addr, 16'(base + 16'(k) - 16'd1));
         chk1("ld_rd", RD, 1'b1);
         chk1("ld_wr", WR, 1'b0);
         chk1("ld_done_early", Done, 1'b0);
         chk1("ld_vwe_early", VecWrEn, 1'b0);
      end
      tick();
      chk1("ld_rd_end", RD, 1'b0);
      chk1("ld_done", Done, 1'b1);
      chk1("ld_vwe", VecWrEn, 1'b1);
      chk1("ld_busy_done", Busy, 1'b1);
      chkv("ld_vec", VecOut, load_vec());
      tick();
      chk1("ld_done_off", Done, 1'b0);
      chk1("ld_vwe_off", VecWrEn, 1'b0);
      chk1("ld_busy_off", Busy, 1'b0);
   endtask

   initial begin
      logic [NELEM*DW-1:0] pat;
      logic                saw_pulse;

      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b1;
      Start    = 1'b0;
      Op       = 1'b0;
      BaseAddr = 16'h0000;
      VecIn    = '0;
      mem_base = 16'h0000;

      // Reset and idle
      tick();
      tick();
      Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk1("rst_busy", Busy, 1'b0);
         chk1("rst_rd", RD, 1'b0);
         chk1("rst_wr", WR, 1'b0);
         chk1("rst_vwe", VecWrEn, 1'b0);
         chk1("rst_done", Done, 1'b0);
         chkv("rst_vec", VecOut, '0);
      end
      chk16("rst_addr", Addr, 16'h0000);
      chk16("rst_dout", DataOut, 16'h0000);

      // Load from 0x0100
      do_load(16'h0100);

      // Store to 0x0200; VecIn is trashed right after the Start edge
      pat      = store_vec();
      VecIn    = pat;
      BaseAddr = 16'h0200;
      Op       = 1'b1;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      VecIn    = '1;
      chk1("st_busy_e0", Busy, 1'b1);
      chk1("st_wr_e0", WR, 1'b0);
      for (int k = 1; k <= NELEM; k++) begin
         tick();
         chk16("st_addr", Addr, 16'(16'h0200 + 16'(k) - 16'd1));
         chk1("st_wr", WR, 1'b1);
         chk1("st_rd", RD, 1'b0);
         chk16("st_dout", DataOut, pat[(k-1)*DW +: DW]);
         chk1("st_vwe", VecWrEn, 1'b0);
      end
      tick();
      chk1("st_wr_end", WR, 1'b0);
      chk1("st_done", Done, 1'b1);
      chk1("st_vwe_done", VecWrEn, 1'b0);
      chkv("st_vec_hold", VecOut, load_vec());
      tick();
      chk1("st_busy_off", Busy, 1'b0);
      chk1("st_done_off", Done, 1'b0);
      chk16("st_addr_hold", Addr, 16'h020F);
      chk16("st_dout_hold", DataOut, 16'h1110);

      // Load wrapping past 0xFFFF
      do_load(16'hFFFF);
      chk16("wrap_elem0", VecOut[15:0], 16'hA000);
      chk16("wrap_elem1", VecOut[31:16], 16'hA001);

      // Start raised in load cycle 5 and held through DONE
      mem_base = 16'h0300;
      BaseAddr = 16'h0300;
      Op       = 1'b0;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      for (int k = 1; k <= NELEM; k++) begin
         tick();
         chk16("ms_addr", Addr, 16'(16'h0300 + 16'(k) - 16'd1));
         chk1("ms_rd", RD, 1'b1);
         chk1("ms_wr", WR, 1'b0);
         if (k == 5) begin
            Start = 1'b1;
            Op    = 1'b1;
         end
      end
      tick();
      chk1("ms_done", Done, 1'b1);
      chk1("ms_vwe", VecWrEn, 1'b1);
      chkv("ms_vec", VecOut, load_vec());
      tick();
      chk1("ms_idle_busy", Busy, 1'b0);
      chk1("ms_idle_wr", WR, 1'b0);
      tick();
      Start = 1'b0;
      chk1("ms_restart_busy", Busy, 1'b1);
      tick();
      chk1("ms_st_wr", WR, 1'b1);
      chk16("ms_st_addr", Addr, 16'h0300);
      chk16("ms_st_dout", DataOut, 16'hFFFF);
      for (int k = 2; k <= NELEM; k++) begin
         tick();
      end
      tick();
      chk1("ms_st_done", Done, 1'b1);
      chk1("ms_st_vwe", VecWrEn, 1'b0);
      tick();
      chk1("ms_st_busy_off", Busy, 1'b0);

      // Reset in load cycle 8
      mem_base = 16'h0400;
      BaseAddr = 16'h0400;
      Op       = 1'b0;
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
      end
      chk1("mr_rd_pre", RD, 1'b1);
      chk16("mr_addr_pre", Addr, 16'h0407);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk1("mr_rd", RD, 1'b0);
      chk1("mr_busy", Busy, 1'b0);
      chk1("mr_done", Done, 1'b0);
      chk1("mr_vwe", VecWrEn, 1'b0);
      chkv("mr_vec", VecOut, '0);
      saw_pulse = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (Done || VecWrEn || Busy || RD) saw_pulse = 1'b1;
      end
      chk1("mr_quiet", saw_pulse, 1'b0);
      do_load(16'h0500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Memory sequencer for the CVP14 vector load (VLD) and vector store (VST) instructions.
- Sits between the processor's external memory port (Addr/RD/WR/DataIn/DataOut) and the vector register file's parallel port (DataIn_p/DataOut_p).
- On Start it moves NELEM consecutive 16-bit words between memory at BaseAddr+i and one vector register.
- For loads it assembles the words into a 256-bit vector and pulses a write enable to the register file. For stores it serialises a snapshot of the vector out to memory.

Parameters:
NELEM, 16, elements per vector (index width 4 bits at default)
DW, 16, element and memory word width in bits

Ports:
Clk1  input  1  clock; all state and outputs update on posedge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin transfer; sampled only in IDLE
Op  input  1  0 = load (VLD), 1 = store (VST); sampled with Start
BaseAddr  input  16  address of element 0; sampled with Start
VecIn  input  NELEM*DW  vector to store (from vReg DataOut_p); sampled with Start
DataIn  input  DW  memory read data; valid the cycle after RD=1
Addr  output  16  memory address (registered)
RD  output  1  memory read strobe (registered)
WR  output  1  memory write strobe (registered)
DataOut  output  DW  memory write data (registered)
VecOut  output  NELEM*DW  assembled load vector (to vReg DataIn_p)
VecWrEn  output  1  one-cycle pulse: VecOut complete, write to vReg
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse at the end of any transfer

Behaviour:
- Reset (synchronous, Clk1, active-high):
  - State is IDLE.
  - Addr, RD, WR, DataOut, VecOut, VecWrEn, Busy and Done are all 0.
  - The internal store buffer and element counter are 0.
  - Reset has priority over every other input.
- States and transitions:
  - IDLE: Start=1 goes to LOAD (Op=0) or STORE (Op=1). Start=0 stays in IDLE.
  - LOAD, STORE: each runs for NELEM cycles, then goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Element layout: element i occupies VecIn/VecOut bits [DW*i+DW-1 : DW*i]. Element i uses address BaseAddr+i, computed modulo 2^16 (FFFF wraps to 0000).
- Edge numbering: edge 0 is the edge that accepts Start; edges 1..NELEM follow.
- Load timing:
  - After edge k (k = 1..NELEM): Addr = BaseAddr+k-1, RD = 1, WR = 0.
  - Edge k+1 captures DataIn into element k-1 of VecOut. Captures occur at edges 2..NELEM+1.
  - After edge NELEM+1: RD = 0, VecOut is complete, and VecWrEn = Done = 1 for exactly one cycle (DONE state).
  - Elements not yet captured keep their previous VecOut value.
- Store timing:
  - Edge 0 snapshots VecIn into an internal buffer, so later VecIn changes are ignored.
  - After edge k (k = 1..NELEM): Addr = BaseAddr+k-1, WR = 1, DataOut = buffer element k-1, RD = 0.
  - After edge NELEM+1: WR = 0 and Done = 1 for one cycle. VecWrEn stays 0.
- Idle output values:
  - Addr and DataOut hold their last values when idle.
  - RD and WR are never 1 in the same cycle.
  - RD and WR are 0 in IDLE and DONE.
- Busy:
  - Busy = 1 from after edge 0 until the DONE to IDLE edge.
  - Start is ignored in every state other than IDLE, including DONE.
  - Back-to-back transfers: Start held high in DONE is ignored. Start sampled in the following IDLE cycle is accepted, giving at least one idle cycle between transfers.
- Total latency: NELEM+2 edges from the Start edge to return to IDLE (18 edges at the default).
- Reset mid-transfer: at the next edge RD, WR, Busy, Done and VecWrEn are 0 and VecOut is cleared. No partial vector is ever announced through VecWrEn.

Test Plan:
- Reset, then idle for 5 cycles -> Busy=RD=WR=VecWrEn=Done=0, VecOut=0.
- Load with BaseAddr=0x0100 and a memory model returning 0xA000+offset -> RD=1 for exactly 16 cycles on Addr 0x0100..0x010F; VecWrEn/Done single pulse after edge 17; VecOut element i = 0xA000+i.
- Store with BaseAddr=0x0200, VecIn element i = 0x1111*(i+1) mod 2^16, VecIn changed to all-ones at edge 1 -> WR=1 for 16 cycles on 0x0200..0x020F; DataOut matches the original pattern; Done pulse; VecWrEn never 1.
- Load with BaseAddr=0xFFFF -> addresses FFFF, 0000, ..., 000E in order; the element from 0000 lands in element 1.
- Start pulsed during LOAD cycle 5 and held through DONE -> no restart mid-transfer; the next transfer begins only from the following IDLE cycle.
- Reset asserted at load cycle 8 -> next edge RD=0, Busy=0, VecOut=0; VecWrEn/Done never pulse; a fresh load afterwards completes normally.
